audio_dac_tx: RTL

Stereo audio DAC serializer. Accepts parallel signed left/right sample pairs from the filter chain over a valid/ready handshake. Generates the codec bit clock and LR clock from the system clock and shifts samples out MSB-first on the DAC data line. It is the transmit end of the codec serial link and sits after the averaging filters, driving the DE2 audio codec DAC pins.

---
 rtl/audio_dac_tx.sv | 105 ++++++++++
 1 files changed

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: stereo DAC serializer, left-justified by default, I2S when AUDIO_DAC_I2S_EN is defined
module audio_dac_tx #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter int SLOT_BITS        = 32,
    parameter int BCLK_DIV         = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AUDIO_DATA_WIDTH-1:0] left,
    input  logic [AUDIO_DATA_WIDTH-1:0] right,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        aud_bclk,
    output logic                        aud_daclrck,
    output logic                        aud_dacdat,
    output logic                        underrun
);
    localparam int DW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int FW  = 2 * SLOT_BITS;
    localparam int CW  = $clog2(FW);
    localparam int PAD = SLOT_BITS - AUDIO_DATA_WIDTH;
`ifdef AUDIO_DAC_I2S_EN
    localparam int   OFF      = 1;
    localparam logic LEFT_LVL = 1'b0;
`else
    localparam int   OFF      = 0;
    localparam logic LEFT_LVL = 1'b1;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state, state_n;
    logic [DW-1:0]               div;
    logic [CW-1:0]               bit_cnt;
    logic [FW-1:0]               shreg;
    logic [FW-1:0]               frame;
    logic [SLOT_BITS-1:0]        slot_l, slot_r;
    logic [AUDIO_DATA_WIDTH-1:0] hold_l, hold_r;
    logic                        fall, start, accept;

    // Event decode and next frame image; an empty holding register (in_ready high) sends silence
    always_comb begin
        fall    = div == DW'(BCLK_DIV - 1);
        start   = fall && bit_cnt == '0;
        accept  = in_valid && in_ready;
        slot_l  = {hold_l, {PAD{1'b0}}} >> OFF;
        slot_r  = {hold_r, {PAD{1'b0}}} >> OFF;
        frame   = in_ready ? '0 : {slot_l, slot_r};
        state_n = state;
        if (state == IDLE && accept) state_n = RUN;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Free-running bit clock divider: low for the first half period, high for the second
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            aud_bclk <= 1'b0;
        end else begin
            div <= fall ? '0 : div + 1'b1;
            if (div == DW'(BCLK_DIV / 2 - 1)) aud_bclk <= 1'b1;
            else if (fall)                    aud_bclk <= 1'b0;
        end
    end

    // Bit counter, LR clock and MSB-first shifter, all advancing on bit clock falls
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            aud_dacdat  <= 1'b0;
            aud_daclrck <= LEFT_LVL;
        end else if (fall) begin
            bit_cnt    <= (bit_cnt == CW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
            aud_dacdat <= start ? frame[FW-1] : shreg[FW-1];
            shreg      <= start ? frame << 1 : shreg << 1;
            if (start)                              aud_daclrck <= LEFT_LVL;
            else if (bit_cnt == CW'(SLOT_BITS))     aud_daclrck <= ~LEFT_LVL;
        end
    end

    // Holding register: filled on handshake, emptied at frame start; in_ready doubles as the empty flag
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b1;
            hold_l   <= '0;
            hold_r   <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= start && in_ready && state == RUN;
            if (accept) begin
                hold_l   <= left;
                hold_r   <= right;
                in_ready <= 1'b0;
            end else if (start) begin
                in_ready <= 1'b1;
            end
        end
    end
endmodule
